paddle_input_ctrl: RTL and testbench
====================================

// Module: paddle_input_ctrl
// PURPOSE
//  Upstream control stage for the VGA pinball display. Conditions the two raw paddle buttons and
//  drives the display's bar-movement inputs to_left, to_right and bar_move_speed.
//  Raw buttons are synchronised and debounced, then resolved to one direction.
//  While a direction is held, bar_move_speed ramps up from a floor to a ceiling.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable I_clk cycles (10 ms @100 MHz) before a debounced level changes
//  RAMP_CYCLES      5000000  I_clk cycles per +1 speed step while held (50 ms @100 MHz)
//  SPEED_MIN        2        speed on press / when idle; legal range 1..SPEED_MAX
//  SPEED_MAX        8        saturation speed; legal range SPEED_MIN..15
// PORTS
//  I_clk           in   1  100 MHz system clock, same clock as the display block
//  I_rst_n         in   1  asynchronous active-low reset
//  btn_left        in   1  raw left button, active-high, asynchronous to I_clk
//  btn_right       in   1  raw right button, active-high, asynchronous to I_clk
//  to_left         out  1  registered: move bar left
//  to_right        out  1  registered: move bar right
//  bar_move_speed  out  4  registered: pixels per frame for the bar
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system):
//   - all synchroniser flops = 0; debounced levels = 0; counters = 0; state = IDLE
//   - to_left = 0, to_right = 0, bar_move_speed = SPEED_MIN
//   - reset asserted mid-ramp or mid-debounce aborts immediately to these values
//  Sync: each button passes through a 2-flop synchroniser.
//  Debounce, per button:
//   - cnt clears whenever the sync level equals the debounced level
//   - otherwise cnt increments; when cnt reaches DEBOUNCE_CYCLES-1, the debounced level flips and cnt clears
//   - a glitch shorter than DEBOUNCE_CYCLES never changes the debounced level
//   - counter width = $clog2(DEBOUNCE_CYCLES)
//  FSM (registered; next state from debounced dl, dr):
//   - IDLE   : dl&!dr -> MOVE_L; dr&!dl -> MOVE_R; else stay
//   - MOVE_L : !dl | dr -> (dr&!dl ? MOVE_R : IDLE)
//   - MOVE_R : !dr | dl -> (dl&!dr ? MOVE_L : IDLE)
//   - both pressed = no movement: stay in IDLE, or exit a MOVE state to IDLE
//   - outputs: to_left = (state==MOVE_L), to_right = (state==MOVE_R); never both 1
//  Latency: raw edge stable from cycle 0 -> to_left/to_right change at cycle 2+DEBOUNCE_CYCLES+1.
//  Speed ramp:
//   - entering any MOVE state (from IDLE or the opposite MOVE): speed = SPEED_MIN, ramp_cnt = 0
//   - in MOVE: ramp_cnt wraps at RAMP_CYCLES-1; on the wrap, speed = min(speed+1, SPEED_MAX)
//   - speed saturates and never wraps past 15
//   - in IDLE: speed = SPEED_MIN, ramp_cnt held at 0
//   - bar_move_speed changes only on I_clk
//   - the display samples it on its own vsync edge; only level stability is required
// CONFIGURATION
//  SPEED_RAMP_EN defined: speed ramp as above.
//  Not defined: ramp counter and logic are removed; bar_move_speed = SPEED_MIN constant.
//   Directions and latency are unchanged.
// STRUCTURE
//  Shared include pinball_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_MOVE_L=2'd1, ST_MOVE_R=2'd2
//   - SPEED_W=4; default SPEED_MIN/SPEED_MAX; 100 MHz timing constants
//  Sub-module btn_debounce (synchroniser + debounce counter, param DEBOUNCE_CYCLES)
//   - instantiated once per button; FSM and ramp live in the top
// TESTING (bench overrides DEBOUNCE_CYCLES=4, RAMP_CYCLES=8, SPEED_MIN=2, SPEED_MAX=5)
//  1 Reset
//    - hold I_rst_n=0 with buttons toggling -> to_left=0, to_right=0, bar_move_speed=2
//    - deassert -> no output change while buttons are 0
//  2 Press and latency
//    - btn_left 0->1 held -> to_left=1 exactly 7 cycles after the edge (2+4+1)
//    - release -> to_left=0 exactly 7 cycles after the release edge
//  3 Glitch rejection
//    - btn_right pulses of 1, 2 and 3 cycles, separated by 10 idle cycles -> to_right stays 0
//  4 Ramp (SPEED_RAMP_EN defined)
//    - hold right -> speed 2,3,4,5 at 8-cycle steps after to_right rises
//    - keep holding 40 more cycles -> stays 5
//    - release -> speed 2 one cycle after to_right falls
//  5 Conflict and reversal
//    - left held until to_left=1, then right pressed -> to_left=0 7 cycles later, to_right stays 0
//    - left released -> to_right=1 with speed 2
//  6 Async reset mid-ramp
//    - assert I_rst_n=0 at speed 4 -> outputs 0/0/2 with no clock edge
//    - rebuild without SPEED_RAMP_EN and rerun scenario 4 -> speed constant 2

Source files
------------

// File: rtl/paddle_input_ctrl_pkg.sv
// Shared definitions for the paddle input path: FSM state encoding, speed width,
// default speed limits and 100 MHz timing constants.
package paddle_input_ctrl_pkg;

  localparam int SPEED_W             = 4;
  localparam int DEF_SPEED_MIN       = 2;
  localparam int DEF_SPEED_MAX       = 8;
  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int DEF_RAMP_CYCLES     = CLK_HZ / 20;   // 50 ms

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a stable-level debounce counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module btn_debounce
  import paddle_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any cycle of agreement restarts the count, so short glitches never land.
      if (sync2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: debounced paddle buttons -> bar direction and move speed.
// Define SPEED_RAMP_EN to ramp bar_move_speed while a direction is held; otherwise it is constant.
module paddle_input_ctrl
  import paddle_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RAMP_CYCLES     = DEF_RAMP_CYCLES,
  parameter int SPEED_MIN       = DEF_SPEED_MIN,
  parameter int SPEED_MAX       = DEF_SPEED_MAX
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic               to_left,
  output logic               to_right,
  output logic [SPEED_W-1:0] bar_move_speed
);

  if (SPEED_MIN < 1 || SPEED_MAX < SPEED_MIN || SPEED_MAX > 15 ||
      RAMP_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("paddle_input_ctrl: illegal parameter set");
  end

  logic   dl;
  logic   dr;
  state_t state;
  state_t state_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .btn_raw (btn_left),
    .btn_db  (dl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .btn_raw (btn_right),
    .btn_db  (dr)
  );

  // Both buttons held means no movement.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dl && !dr)      state_nxt = ST_MOVE_L;
        else if (dr && !dl) state_nxt = ST_MOVE_R;
      end
      ST_MOVE_L: if (!dl || dr) state_nxt = (dr && !dl) ? ST_MOVE_R : ST_IDLE;
      ST_MOVE_R: if (!dr || dl) state_nxt = (dl && !dr) ? ST_MOVE_L : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state    <= ST_IDLE;
      to_left  <= 1'b0;
      to_right <= 1'b0;
    end else begin
      state    <= state_nxt;
      to_left  <= (state_nxt == ST_MOVE_L);
      to_right <= (state_nxt == ST_MOVE_R);
    end
  end

`ifdef SPEED_RAMP_EN
  localparam int RW = cnt_w(RAMP_CYCLES);

  logic [RW-1:0]      ramp_cnt;
  logic [SPEED_W-1:0] speed;
  logic               entering_move;

  assign entering_move = (state_nxt != state) && (state_nxt != ST_IDLE);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ramp_cnt <= '0;
      speed    <= SPEED_W'(SPEED_MIN);
    end else if (state == ST_IDLE || entering_move) begin
      ramp_cnt <= '0;
      speed    <= SPEED_W'(SPEED_MIN);
    end else if (ramp_cnt == RW'(RAMP_CYCLES - 1)) begin
      ramp_cnt <= '0;
      if (speed < SPEED_W'(SPEED_MAX)) speed <= speed + SPEED_W'(1);
    end else begin
      ramp_cnt <= ramp_cnt + RW'(1);
    end
  end

  assign bar_move_speed = speed;
`else
  assign bar_move_speed = SPEED_W'(SPEED_MIN);
`endif

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: directed vector table, hand-written corner sequences
// and random button activity checked against a behavioural model every cycle.
module tb_paddle_input_ctrl;

  localparam int DEB  = 4;
  localparam int RAMP = 8;
  localparam int SMIN = 2;
  localparam int SMAX = 5;
`ifdef SPEED_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  // clock / reset
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       bl    = 1'b0;
  logic       br    = 1'b0;
  logic       tl;
  logic       tr;
  logic [3:0] spd;

  always #5 clk = ~clk;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .RAMP_CYCLES     (RAMP),
    .SPEED_MIN       (SMIN),
    .SPEED_MAX       (SMAX)
  ) dut (
    .I_clk          (clk),
    .I_rst_n        (rst_n),
    .btn_left       (bl),
    .btn_right      (br),
    .to_left        (tl),
    .to_right       (tr),
    .bar_move_speed (spd)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected speed once the ramp feature is taken into account.
  function automatic int sp(input int ramp_val);
    return RAMP_ON ? ramp_val : SMIN;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit hl[$];
  bit hr[$];
  bit m_dl, m_dr;
  int m_run_l, m_run_r;
  int m_dir;   // 0 none, 1 left, 2 right
  int m_h;     // edges spent in the current direction
  int m_spd;

  function automatic void model_reset();
    hl = '{1'b0, 1'b0};
    hr = '{1'b0, 1'b0};
    m_dl = 1'b0; m_dr = 1'b0;
    m_run_l = 0; m_run_r = 0;
    m_dir = 0; m_h = 0; m_spd = SMIN;
  endfunction

  function automatic void model_step(input bit rl, input bit rr);
    bit sl, sr, pl, pr;
    int nd, v;
    sl = hl.pop_front(); hl.push_back(rl);
    sr = hr.pop_front(); hr.push_back(rr);
    pl = m_dl; pr = m_dr;
    if (sl != m_dl) begin
      m_run_l++;
      if (m_run_l == DEB) begin m_dl = sl; m_run_l = 0; end
    end else m_run_l = 0;
    if (sr != m_dr) begin
      m_run_r++;
      if (m_run_r == DEB) begin m_dr = sr; m_run_r = 0; end
    end else m_run_r = 0;
    nd = (pl && !pr) ? 1 : ((pr && !pl) ? 2 : 0);
    if (m_dir == 0 || (nd != m_dir && nd != 0)) begin
      m_h = 0; m_spd = SMIN;
    end else begin
      m_h++;
      v = SMIN + m_h / RAMP;
      m_spd = (v > SMAX) ? SMAX : v;
    end
    m_dir = nd;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(bl, br);
    else       model_reset();
    @(negedge clk);
    check("mdl_left",  tl,  (m_dir == 1) ? 1 : 0);
    check("mdl_right", tr,  (m_dir == 2) ? 1 : 0);
    check("mdl_speed", spd, sp(m_spd));
  endtask

  task automatic wait_for(input string name, input bit right, input bit val, input int budget);
    int n = 0;
    while (((right ? tr : tl) != val) && n < budget) begin
      tick();
      n++;
    end
    check(name, right ? tr : tl, val);
  endtask

  typedef struct {
    bit l;
    bit r;
    int cyc;
    bit el;
    bit er;
    int es;
  } vec_t;

  vec_t tbl[14];

  initial begin : main
    model_reset();
    tbl[0]  = '{0, 0, 3,  0, 0, SMIN};
    tbl[1]  = '{1, 0, 6,  0, 0, SMIN};     // one edge short of the latency
    tbl[2]  = '{1, 0, 1,  1, 0, SMIN};     // 2+4+1 edges after the press
    tbl[3]  = '{1, 0, 8,  1, 0, sp(3)};
    tbl[4]  = '{0, 0, 6,  1, 0, sp(3)};
    tbl[5]  = '{0, 0, 1,  0, 0, sp(3)};    // release lands, ramp value still visible
    tbl[6]  = '{0, 0, 1,  0, 0, SMIN};
    tbl[7]  = '{0, 1, 7,  0, 1, SMIN};
    tbl[8]  = '{1, 1, 7,  0, 0, SMIN};     // both held -> stop
    tbl[9]  = '{1, 0, 7,  1, 0, SMIN};
    tbl[10] = '{1, 0, 16, 1, 0, sp(4)};
    tbl[11] = '{0, 1, 6,  1, 0, sp(4)};
    tbl[12] = '{0, 1, 1,  0, 1, SMIN};     // direct reversal restarts at the floor
    tbl[13] = '{0, 0, 7,  0, 0, SMIN};

    // 1: reset held with buttons toggling
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      tick();
      check("rst_left", tl, 0);
      check("rst_right", tr, 0);
      check("rst_speed", spd, SMIN);
    end
    bl = 1'b0; br = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_left", tl, 0);
    check("post_rst_right", tr, 0);
    check("post_rst_speed", spd, SMIN);

    // 2: vector table (press/release latency, ramp, conflict, reversal)
    for (int i = 0; i < 14; i++) begin
      bl = tbl[i].l;
      br = tbl[i].r;
      for (int c = 0; c < tbl[i].cyc; c++) tick();
      check($sformatf("vec%0d_left", i),  tl,  tbl[i].el);
      check($sformatf("vec%0d_right", i), tr,  tbl[i].er);
      check($sformatf("vec%0d_speed", i), spd, tbl[i].es);
    end

    // 3: glitch rejection
    for (int w = 1; w <= 3; w++) begin
      br = 1'b1;
      for (int c = 0; c < w; c++) tick();
      br = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        check($sformatf("glitch%0d_right", w), tr, 0);
      end
    end

    // 4: ramp while holding right
    br = 1'b1;
    wait_for("ramp_rise", 1'b1, 1'b1, 20);
    check("ramp_s0", spd, SMIN);
    for (int s = 1; s <= 3; s++) begin
      for (int c = 0; c < 7; c++) tick();
      check($sformatf("ramp_hold%0d", s), spd, sp(SMIN + s - 1));
      tick();
      check($sformatf("ramp_step%0d", s), spd, sp(SMIN + s));
    end
    for (int c = 0; c < 40; c++) tick();
    check("ramp_sat", spd, sp(SMAX));
    br = 1'b0;
    wait_for("ramp_fall", 1'b1, 1'b0, 20);
    check("ramp_fall_speed", spd, sp(SMAX));
    tick();
    check("ramp_idle_speed", spd, SMIN);

    // 5: conflict then hand-over to right
    bl = 1'b1;
    wait_for("conf_left", 1'b0, 1'b1, 20);
    br = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("conf_hold_left", tl, 1);
    tick();
    check("conf_stop_left", tl, 0);
    check("conf_stop_right", tr, 0);
    bl = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("conf_right", tr, 1);
    check("conf_speed", spd, SMIN);
    br = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    // 6: async reset mid-ramp
    br = 1'b1;
    wait_for("arst_rise", 1'b1, 1'b1, 20);
    for (int c = 0; c < 16; c++) tick();
    check("arst_pre_speed", spd, sp(4));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_left", tl, 0);
    check("arst_right", tr, 0);
    check("arst_speed", spd, SMIN);
    tick();
    br = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();

    // random button activity against the model
    for (int seg = 0; seg < 300; seg++) begin
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < int'($urandom_range(20, 45)); c++) tick();
      end else begin
        for (int c = 0; c < int'($urandom_range(1, 8)); c++) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
